// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: cursor column, player turn, token drop animation and commit strobe.
// Optional per-turn move timer is built only when SCORE4_TURN_TIMER_EN is defined.
module turn_controller #(
    parameter int unsigned ROWS       = 6,
    parameter int unsigned COLS       = 7,
    parameter int unsigned DROP_TICKS = 2_500_000,
    parameter int unsigned TURN_TICKS = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              left_pulse,
    input  logic              right_pulse,
    input  logic              put_pulse,
    input  logic [COLS*3-1:0] col_height,
    input  logic              win_a,
    input  logic              win_b,
    input  logic              full_panel,
    output logic [2:0]        column,
    output logic              turn,
    output logic              drop_active,
    output logic [2:0]        drop_row,
    output logic              commit,
    output logic [2:0]        commit_col,
    output logic [2:0]        commit_row,
    output logic              invalid_move,
    output logic              timeout,
    output logic              game_over,
    output logic              new_game
);

    typedef enum logic [1:0] {S_WAIT, S_DROP, S_CHECK, S_OVER} state_t;

    localparam int unsigned     TICK_W    = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DROP_TICKS - 1);
    localparam logic [2:0]      ROW_TOP   = 3'(ROWS - 1);
    localparam logic [2:0]      ROW_FULL  = 3'(ROWS);
    localparam logic [2:0]      COL_LAST  = 3'(COLS - 1);

    state_t            state, state_next;
    logic [2:0]        column_d, drop_row_d, target_q, target_d, tcol_q, tcol_d;
    logic              turn_d, invalid_d, timeout_d, new_game_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        chk_q, chk_d;
    logic [2:0]        cur_height;
    logic              timer_expired, timer_reload, timer_hold;

    assign cur_height  = col_height[3*column +: 3];
    assign drop_active = (state == S_DROP);
    assign game_over   = (state == S_OVER);
    assign commit      = (state == S_CHECK) && (chk_q == 2'd0);
    assign commit_col  = tcol_q;
    assign commit_row  = target_q;

    always_comb begin
        state_next   = state;
        column_d     = column;
        turn_d       = turn;
        drop_row_d   = drop_row;
        target_d     = target_q;
        tcol_d       = tcol_q;
        tick_d       = tick_q;
        chk_d        = chk_q;
        invalid_d    = 1'b0;
        timeout_d    = 1'b0;
        new_game_d   = 1'b0;
        timer_reload = 1'b0;
        timer_hold   = 1'b0;
        case (state)
            S_WAIT: begin
                if (put_pulse) begin
                    if (cur_height >= ROW_FULL) begin
                        invalid_d  = 1'b1;
                        timer_hold = 1'b1;
                    end else begin
                        target_d   = cur_height;
                        tcol_d     = column;
                        drop_row_d = ROW_TOP;
                        tick_d     = '0;
                        state_next = S_DROP;
                    end
                end else begin
                    if (timer_expired) begin
                        timeout_d    = 1'b1;
                        turn_d       = ~turn;
                        timer_reload = 1'b1;
                    end
                    if (left_pulse && !right_pulse)
                        column_d = (column == 3'd0) ? COL_LAST : column - 3'd1;
                    else if (right_pulse && !left_pulse)
                        column_d = (column == COL_LAST) ? 3'd0 : column + 3'd1;
                end
            end
            S_DROP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (drop_row == target_q) begin
                        chk_d      = 2'd0;
                        state_next = S_CHECK;
                    end else begin
                        drop_row_d = drop_row - 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_CHECK: begin
                chk_d = chk_q + 2'd1;
                // Third cycle: the datapath's registered win flags now reflect the committed token.
                if (chk_q == 2'd2) begin
                    if (win_a || win_b || full_panel) begin
                        state_next = S_OVER;
                    end else begin
                        turn_d       = ~turn;
                        timer_reload = 1'b1;
                        state_next   = S_WAIT;
                    end
                end
            end
            S_OVER: begin
                if (put_pulse) begin
                    new_game_d   = 1'b1;
                    column_d     = 3'd0;
                    turn_d       = 1'b0;
                    timer_reload = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            default: state_next = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_WAIT;
            column       <= '0;
            turn         <= 1'b0;
            drop_row     <= ROW_TOP;
            target_q     <= '0;
            tcol_q       <= '0;
            tick_q       <= '0;
            chk_q        <= '0;
            invalid_move <= 1'b0;
            timeout      <= 1'b0;
            new_game     <= 1'b0;
        end else begin
            state        <= state_next;
            column       <= column_d;
            turn         <= turn_d;
            drop_row     <= drop_row_d;
            target_q     <= target_d;
            tcol_q       <= tcol_d;
            tick_q       <= tick_d;
            chk_q        <= chk_d;
            invalid_move <= invalid_d;
            timeout      <= timeout_d;
            new_game     <= new_game_d;
        end
    end

`ifdef SCORE4_TURN_TIMER_EN
    localparam int unsigned      TMR_W    = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TICKS - 1);

    logic [TMR_W-1:0] timer_q;

    assign timer_expired = (timer_q == TMR_LAST);

    // A put on a full column freezes the timer so an expiry it displaced fires next cycle.
    always_ff @(posedge clk) begin
        if (rst || timer_reload)
            timer_q <= '0;
        else if (state == S_WAIT && !timer_hold)
            timer_q <= timer_q + 1'b1;
    end
`else
    logic unused_timer;

    assign timer_expired = 1'b0;
    assign unused_timer  = timer_reload ^ timer_hold ^ (TURN_TICKS != 0);
`endif

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: elapsed-time reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_turn_controller;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int DT   = 2;
    localparam int TT   = 20;

`ifdef SCORE4_TURN_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, left_pulse, right_pulse, put_pulse;
    logic [COLS*3-1:0] col_height;
    logic              win_a, win_b, full_panel;
    logic [2:0]        column, drop_row, commit_col, commit_row;
    logic              turn, drop_active, commit, invalid_move, timeout, game_over, new_game;

    int heights [COLS];

    always #5 clk = ~clk;

    always_comb begin
        col_height = '0;
        for (int i = 0; i < COLS; i++) col_height[i*3 +: 3] = 3'(heights[i]);
    end

    turn_controller #(
        .ROWS(ROWS), .COLS(COLS), .DROP_TICKS(DT), .TURN_TICKS(TT)
    ) dut (
        .clk(clk), .rst(rst),
        .left_pulse(left_pulse), .right_pulse(right_pulse), .put_pulse(put_pulse),
        .col_height(col_height), .win_a(win_a), .win_b(win_b), .full_panel(full_panel),
        .column(column), .turn(turn), .drop_active(drop_active), .drop_row(drop_row),
        .commit(commit), .commit_col(commit_col), .commit_row(commit_row),
        .invalid_move(invalid_move), .timeout(timeout), .game_over(game_over),
        .new_game(new_game)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: game phase plus elapsed cycles since the token started falling.
    localparam int M_WAIT = 0, M_MOVE = 1, M_OVER = 2;
    int m_mode = M_WAIT, m_col = 0, m_turn = 0, m_tcol = 0, m_target = 0;
    int m_t0 = 0, m_last_row = ROWS - 1, m_timer = 0, cyc = 0, me;
    bit m_inv = 1'b0, m_to = 1'b0, m_ng = 1'b0;

    always @(posedge clk) begin
        m_inv = 1'b0; m_to = 1'b0; m_ng = 1'b0;
        if (rst) begin
            m_mode = M_WAIT; m_col = 0; m_turn = 0; m_last_row = ROWS - 1; m_timer = 0;
        end else begin
            case (m_mode)
                M_WAIT: begin
                    if (put_pulse) begin
                        if (heights[m_col] >= ROWS) begin
                            m_inv = 1'b1;
                        end else begin
                            m_mode = M_MOVE; m_tcol = m_col; m_target = heights[m_col];
                            m_t0 = cyc + 1; m_last_row = m_target;
                        end
                    end else begin
                        if (TIMER_ON && m_timer == TT - 1) begin
                            m_to = 1'b1; m_turn = 1 - m_turn; m_timer = 0;
                        end else begin
                            m_timer++;
                        end
                        if (left_pulse && !right_pulse) m_col = (m_col + COLS - 1) % COLS;
                        else if (right_pulse && !left_pulse) m_col = (m_col + 1) % COLS;
                    end
                end
                M_MOVE: begin
                    me = cyc - m_t0;
                    if (me == (ROWS - m_target) * DT + 2) begin
                        if (win_a || win_b || full_panel) begin
                            m_mode = M_OVER;
                        end else begin
                            m_turn = 1 - m_turn; m_mode = M_WAIT; m_timer = 0;
                        end
                    end
                end
                default: begin
                    if (put_pulse) begin
                        m_ng = 1'b1; m_col = 0; m_turn = 0; m_mode = M_WAIT; m_timer = 0;
                    end
                end
            endcase
        end
        cyc++;
    end

    int ce, cdw, x_row;
    bit x_drop, x_commit;

    always @(negedge clk) begin
        if (chk_en) begin
            ce       = cyc - m_t0;
            cdw      = (ROWS - m_target) * DT;
            x_drop   = (m_mode == M_MOVE) && (ce < cdw);
            x_commit = (m_mode == M_MOVE) && (ce == cdw);
            x_row    = (m_mode != M_MOVE) ? m_last_row
                     : (ce < cdw) ? ROWS - 1 - ce / DT : m_target;
            check("m_column", column, m_col);
            check("m_turn", turn, m_turn);
            check("m_drop_active", drop_active, x_drop);
            check("m_drop_row", drop_row, x_row);
            check("m_commit", commit, x_commit);
            if (x_commit) begin
                check("m_commit_col", commit_col, m_tcol);
                check("m_commit_row", commit_row, m_target);
            end
            check("m_invalid_move", invalid_move, m_inv);
            check("m_timeout", timeout, m_to);
            check("m_game_over", game_over, m_mode == M_OVER);
            check("m_new_game", new_game, m_ng);
        end
    end

    task automatic step(input logic l, input logic r, input logic p);
        left_pulse = l; right_pulse = r; put_pulse = p;
        @(negedge clk);
        left_pulse = 1'b0; right_pulse = 1'b0; put_pulse = 1'b0;
    endtask

    initial begin
        rst = 1'b1; left_pulse = 1'b0; right_pulse = 1'b0; put_pulse = 1'b0;
        win_a = 1'b0; win_b = 1'b0; full_panel = 1'b0;
        foreach (heights[i]) heights[i] = 0;
        @(negedge clk); @(negedge clk);
        chk_en = 1'b1;
        check("rst_column", column, 0);
        check("rst_turn", turn, 0);
        check("rst_drop_row", drop_row, 5);
        check("rst_game_over", game_over, 0);
        rst = 1'b0;

        // cursor wrap and simultaneous left/right
        step(1, 0, 0); check("wrap_left", column, 6);
        step(0, 1, 0); check("wrap_right", column, 0);
        step(1, 1, 0); check("left_right_same", column, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        check("cursor_col3", column, 3);

        // full-height drop into empty column 3
        step(0, 0, 1);
        for (int j = 1; j <= 12; j++) begin
            check("drop_active", drop_active, 1);
            check("drop_row_step", drop_row, 5 - (j - 1) / 2);
            check("no_early_commit", commit, 0);
            @(negedge clk);
        end
        check("commit_at_13", commit, 1);
        check("commit_col", commit_col, 3);
        check("commit_row", commit_row, 0);
        @(negedge clk); @(negedge clk);
        check("turn_before_toggle", turn, 0);
        @(negedge clk);
        check("turn_after_toggle", turn, 1);

        // put on a full column
        heights[2] = 6;
        step(1, 0, 0); check("cursor_col2", column, 2);
        step(0, 0, 1);
        check("invalid_pulse", invalid_move, 1);
        check("invalid_no_drop", drop_active, 0);
        @(negedge clk);
        check("invalid_one_cycle", invalid_move, 0);
        check("invalid_turn_kept", turn, 1);

        // winning move, then new game
        heights[2] = 4;
        step(0, 0, 1);
        repeat (3) @(negedge clk);
        check("short_no_commit", commit, 0);
        @(negedge clk);
        check("short_commit", commit, 1);
        check("short_commit_row", commit_row, 4);
        check("short_commit_col", commit_col, 2);
        @(negedge clk); win_b = 1'b1;
        @(negedge clk); check("over_not_yet", game_over, 0);
        @(negedge clk);
        check("game_over", game_over, 1);
        check("over_turn_kept", turn, 1);
        step(1, 0, 0);
        check("over_ignores_left", column, 2);
        win_b = 1'b0;
        step(0, 0, 1);
        check("new_game_pulse", new_game, 1);
        check("new_game_col", column, 0);
        check("new_game_turn", turn, 0);
        check("new_game_wait", game_over, 0);
        @(negedge clk);
        check("new_game_one_cycle", new_game, 0);

        // reset in the middle of a drop
        heights[2] = 0;
        step(0, 1, 0);
        step(0, 0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_drop_active", drop_active, 0);
        check("rst_mid_column", column, 0);
        check("rst_mid_drop_row", drop_row, 5);
        check("rst_mid_turn", turn, 0);
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check("no_commit_after_rst", commit, 0);
        end

`ifdef SCORE4_TURN_TIMER_EN
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("timeout_at_20", timeout, (i == 20) ? 1 : 0);
        end
        check("timeout_turn_flip", turn, 1);
        @(negedge clk);
        check("timeout_one_cycle", timeout, 0);
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("no_timeout", timeout, 0);
        end
        check("idle_turn_kept", turn, 0);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
